// File: rtl/pe_mac_seq_if.sv
// pe_mac_seq_if: operand-in / result-out handshake bundle for the sequential
// dot-product processing element.
//   slave  : seen by pe_mac_seq (consumes operands, produces the result)
//   master : seen by the operand source / result sink
interface pe_mac_seq_if #(
    parameter int A = 8,
    parameter int B = 8,
    parameter int N = 3,
    parameter int O = A + B + 2
);
    logic           i_valid;
    logic           o_ready;
    logic [N*A-1:0] pe_mul_a;
    logic [N*B-1:0] pe_mul_b;
    logic           o_valid;
    logic           i_ready;
    logic [O-1:0]   o_out;

    modport slave (
        input  i_valid,
        input  pe_mul_a,
        input  pe_mul_b,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_out
    );

    modport master (
        output i_valid,
        output pe_mul_a,
        output pe_mul_b,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_out
    );
endinterface

// File: rtl/pe_mac_seq.sv
// pe_mac_seq: sequential dot-product processing element.
// Latches N lanes of a/b operands, accumulates a[k]*b[k] one lane per cycle
// with a single multiplier, then presents the sum over a valid/ready handshake.
// Optional build macro PE_MAC_SEQ_SIGNED_EN: lanes are two's complement and
// products are sign-extended before accumulation; otherwise unsigned with
// zero extension. Handshake and latency are identical in both builds.
module pe_mac_seq #(
    parameter int A = 8,
    parameter int B = 8,
    parameter int N = 3,
    parameter int O = A + B + 2
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    pe_mac_seq_if.slave   bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t         state_reg;
    state_t         state_next;
    logic           ready_reg;
    logic [CW-1:0]  k_reg;
    logic [O-1:0]   acc_reg;
    logic [O-1:0]   out_reg;
    logic [A-1:0]   a_lane_reg [N];
    logic [B-1:0]   b_lane_reg [N];

    logic           accept;
    logic           last_lane;
    logic [A-1:0]   a_cur;
    logic [B-1:0]   b_cur;
    logic [A+B-1:0] prod;
    logic [O-1:0]   prod_ext;
    logic [O-1:0]   sum;

    // ready_reg is only ever high in IDLE, so it alone qualifies the accept
    assign accept    = bus.i_valid && ready_reg;
    assign last_lane = (k_reg == CW'(N - 1));
    assign a_cur     = a_lane_reg[k_reg];
    assign b_cur     = b_lane_reg[k_reg];

    // Single shared multiplier: full-width product of the current lane, extended to accumulator width
    always_comb begin
`ifdef PE_MAC_SEQ_SIGNED_EN
        prod     = $signed({{B{a_cur[A-1]}}, a_cur}) * $signed({{A{b_cur[B-1]}}, b_cur});
        prod_ext = O'($signed(prod));
`else
        prod     = {{B{1'b0}}, a_cur} * {{A{1'b0}}, b_cur};
        prod_ext = O'(prod);
`endif
        sum = acc_reg + prod_ext;
    end

    // State register; o_ready is registered from the next state so it stays low during reset
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == IDLE);
        end
    end

    // Next-state decode: accept -> N multiply cycles -> hold result until the sink takes it
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)      state_next = MUL;
            MUL:     if (last_lane)   state_next = DONE;
            DONE:    if (bus.i_ready) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Output decode: result is valid exactly while waiting in DONE
    always_comb begin
        bus.o_ready = ready_reg;
        bus.o_valid = (state_reg == DONE);
        bus.o_out   = out_reg;
    end

    // Operand capture, one register pair per lane, loaded only on the accept edge
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            always_ff @(posedge i_clk or negedge i_resetn) begin
                if (!i_resetn) begin
                    a_lane_reg[gi] <= '0;
                    b_lane_reg[gi] <= '0;
                end else if (state_reg == IDLE && accept) begin
                    a_lane_reg[gi] <= bus.pe_mul_a[gi*A +: A];
                    b_lane_reg[gi] <= bus.pe_mul_b[gi*B +: B];
                end
            end
        end
    endgenerate

    // Accumulator, lane counter and result register
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            acc_reg <= '0;
            k_reg   <= '0;
            out_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        acc_reg <= '0;
                        k_reg   <= '0;
                    end
                end
                MUL: begin
                    acc_reg <= sum;
                    if (last_lane) begin
                        out_reg <= sum;
                        k_reg   <= '0;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_mac_seq.sv
// tb_pe_mac_seq: self-checking bench for pe_mac_seq. Expected sums come from a
// plain-arithmetic dot-product model; one task per scenario.
module tb_pe_mac_seq;
    localparam int A = 8;
    localparam int B = 8;
    localparam int N = 3;
    localparam int O = A + B + 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pe_mac_seq_if #(.A(A), .B(B), .N(N), .O(O)) bus ();

    pe_mac_seq #(.A(A), .B(B), .N(N), .O(O)) dut (
        .i_clk    (clk),
        .i_resetn (rst_n),
        .bus      (bus)
    );

    // Reference: sum of lane products in wide integer arithmetic
    function automatic logic [O-1:0] ref_dot(input logic [N*A-1:0] va, input logic [N*B-1:0] vb);
        longint s;
        logic [A-1:0] la;
        logic [B-1:0] lb;
        s = 0;
        for (int k = 0; k < N; k++) begin
            la = va[k*A +: A];
            lb = vb[k*B +: B];
`ifdef PE_MAC_SEQ_SIGNED_EN
            s += longint'($signed(la)) * longint'($signed(lb));
`else
            s += longint'(la) * longint'(lb);
`endif
        end
        return s[O-1:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vec(output logic [N*A-1:0] va, output logic [N*B-1:0] vb);
        for (int k = 0; k < N; k++) begin
            va[k*A +: A] = A'($urandom);
            vb[k*B +: B] = B'($urandom);
        end
    endtask

    // Present one vector for exactly one edge (caller ensures o_ready is high)
    task automatic send(input logic [N*A-1:0] va, input logic [N*B-1:0] vb);
        bus.pe_mul_a = va;
        bus.pe_mul_b = vb;
        bus.i_valid  = 1'b1;
        tick();
        bus.i_valid  = 1'b0;
        bus.pe_mul_a = '0;
        bus.pe_mul_b = '0;
    endtask

    // Count edges until o_valid, bounded
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.o_valid && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.pe_mul_a = '0;
        bus.pe_mul_b = '0;
        repeat (3) tick();
        checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.o_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_out !== '0) begin errors++; $display("FAIL reset_out got=%h exp=0", bus.o_out); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", bus.o_ready); end
        $display("test_reset: done");
    endtask

    task automatic test_basic;
        logic [N*A-1:0] va;
        logic [N*B-1:0] vb;
        int cyc;
        va = {8'h30, 8'h14, 8'h30};
        vb = {8'h48, 8'h3C, 8'h48};
        bus.i_ready = 1'b1;
        send(va, vb);
        wait_valid(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", cyc); end
        checks++; if (bus.o_out !== 18'h01FB0) begin errors++; $display("FAIL basic_out got=%h exp=01fb0", bus.o_out); end
        tick();
        checks++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL basic_handoff got valid=%b ready=%b exp valid=0 ready=1", bus.o_valid, bus.o_ready);
        end
        $display("test_basic: out=%h latency=%0d", bus.o_out, cyc);
    endtask

    task automatic test_max;
        logic [N*A-1:0] va;
        logic [N*B-1:0] vb;
        logic [O-1:0] exp_out;
        int cyc;
        va = '1;
        vb = '1;
`ifdef PE_MAC_SEQ_SIGNED_EN
        exp_out = 18'h00003;
`else
        exp_out = 18'h2FA03;
`endif
        bus.i_ready = 1'b1;
        send(va, vb);
        wait_valid(cyc);
        checks++; if (cyc !== 3 || bus.o_out !== exp_out) begin
            errors++; $display("FAIL max_out got=%h lat=%0d exp=%h lat=3", bus.o_out, cyc, exp_out);
        end
        tick();
        $display("test_max: out=%h", exp_out);
    endtask

    task automatic test_signed_vec;
        logic [N*A-1:0] va;
        logic [N*B-1:0] vb;
        logic [O-1:0] exp_out;
        int cyc;
        va = {8'h00, 8'h00, 8'hF0};
        vb = {8'h00, 8'h00, 8'h20};
`ifdef PE_MAC_SEQ_SIGNED_EN
        exp_out = 18'h3FE00;
`else
        exp_out = 18'h01E00;
`endif
        bus.i_ready = 1'b1;
        send(va, vb);
        wait_valid(cyc);
        checks++; if (cyc !== 3 || bus.o_out !== exp_out) begin
            errors++; $display("FAIL signed_vec got=%h lat=%0d exp=%h lat=3", bus.o_out, cyc, exp_out);
        end
        tick();
        $display("test_signed_vec: out=%h", exp_out);
    endtask

    task automatic test_backpressure;
        logic [N*A-1:0] va2;
        logic [N*B-1:0] vb2;
        logic [O-1:0] exp2;
        int cyc;
        bus.i_ready = 1'b0;
        send({8'h30, 8'h14, 8'h30}, {8'h48, 8'h3C, 8'h48});
        wait_valid(cyc);
        rand_vec(va2, vb2);
        exp2 = ref_dot(va2, vb2);
        bus.pe_mul_a = va2;
        bus.pe_mul_b = vb2;
        bus.i_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.o_valid !== 1'b1 || bus.o_out !== 18'h01FB0 || bus.o_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc=%0d got valid=%b out=%h ready=%b exp 1/01fb0/0", i, bus.o_valid, bus.o_out, bus.o_ready);
            end
            tick();
        end
        bus.i_ready = 1'b1;
        tick();
        checks++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL bp_handoff got valid=%b ready=%b exp 0/1", bus.o_valid, bus.o_ready);
        end
        tick();
        bus.i_valid = 1'b0;
        checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got ready=%b exp=0", bus.o_ready); end
        wait_valid(cyc);
        checks++; if (cyc !== 3 || bus.o_out !== exp2) begin
            errors++; $display("FAIL bp_second_out got=%h lat=%0d exp=%h lat=3", bus.o_out, cyc, exp2);
        end
        tick();
        $display("test_backpressure: second out=%h", exp2);
    endtask

    task automatic test_reset_mid;
        logic [N*A-1:0] va;
        logic [N*B-1:0] vb;
        logic [O-1:0] exp_out;
        int cyc;
        bus.i_ready = 1'b1;
        va = {8'hFF, 8'hFF, 8'hFF};
        vb = {8'h11, 8'h22, 8'h33};
        send(va, vb);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0 || bus.o_out !== '0 || bus.o_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got valid=%b out=%h ready=%b exp 0/0/0", bus.o_valid, bus.o_out, bus.o_ready);
        end
        repeat (4) tick();
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_hold got valid=%b exp=0", bus.o_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", bus.o_ready); end
        va = {8'h01, 8'h02, 8'h03};
        vb = {8'h04, 8'h05, 8'h06};
        exp_out = ref_dot(va, vb);
        send(va, vb);
        wait_valid(cyc);
        checks++; if (cyc !== 3 || bus.o_out !== exp_out) begin
            errors++; $display("FAIL rstmid_after got=%h lat=%0d exp=%h lat=3", bus.o_out, cyc, exp_out);
        end
        tick();
        $display("test_reset_mid: post-reset out=%h", exp_out);
    endtask

    task automatic test_random;
        logic [N*A-1:0] va;
        logic [N*B-1:0] vb;
        logic [O-1:0] exp_out;
        int cyc;
        int hold;
        for (int t = 0; t < 12; t++) begin
            rand_vec(va, vb);
            exp_out = ref_dot(va, vb);
            bus.i_ready = 1'b0;
            send(va, vb);
            wait_valid(cyc);
            hold = int'($urandom_range(0, 3));
            repeat (hold) tick();
            checks++; if (cyc !== 3 || bus.o_valid !== 1'b1 || bus.o_out !== exp_out) begin
                errors++; $display("FAIL random[%0d] got=%h valid=%b lat=%0d exp=%h lat=3", t, bus.o_out, bus.o_valid, cyc, exp_out);
            end
            bus.i_ready = 1'b1;
            tick();
            bus.i_ready = 1'b0;
            $display("test_random[%0d]: a=%h b=%h out=%h", t, va, vb, exp_out);
        end
    endtask

    task automatic test_back_to_back;
        logic [N*A-1:0] va [4];
        logic [N*B-1:0] vb [4];
        logic [O-1:0] exp_q [$];
        logic [O-1:0] exp_out;
        int idx;
        int got;
        int last_cyc;
        bit acc;
        for (int i = 0; i < 4; i++) begin
            rand_vec(va[i], vb[i]);
            va[i][7:0] = 8'(i + 1);
            exp_q.push_back(ref_dot(va[i], vb[i]));
        end
        idx = 0;
        got = 0;
        last_cyc = 0;
        bus.i_ready  = 1'b1;
        bus.pe_mul_a = va[0];
        bus.pe_mul_b = vb[0];
        bus.i_valid  = 1'b1;
        for (int cyc = 1; cyc <= 80 && got < 4; cyc++) begin
            acc = bus.i_valid && bus.o_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    bus.pe_mul_a = va[idx];
                    bus.pe_mul_b = vb[idx];
                end else begin
                    bus.i_valid = 1'b0;
                end
            end
            if (bus.o_valid) begin
                exp_out = exp_q.pop_front();
                checks++; if (bus.o_out !== exp_out) begin
                    errors++; $display("FAIL b2b_out[%0d] got=%h exp=%h", got, bus.o_out, exp_out);
                end
                if (got > 0) begin
                    checks++; if (cyc - last_cyc !== 5) begin
                        errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=5", got, cyc - last_cyc);
                    end
                end
                $display("test_back_to_back: result %0d out=%h at cycle %0d", got, exp_out, cyc);
                last_cyc = cyc;
                got++;
            end
        end
        bus.i_valid = 1'b0;
        repeat (8) begin
            tick();
            checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra got valid=%b exp=0", bus.o_valid); end
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_signed_vec();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
